// File: rtl/track_pkg.sv
// track_pkg: shared definitions for the note track redraw logic.
//   - 3-bit RGB colour codes used on the VGA write port
//   - scheduler state encoding
//   - default geometry of the note track
//   - slot colour selection helper
package track_pkg;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] BLUE   = 3'b001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAW   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int DEF_NUM_SLOTS  = 10;
  localparam int DEF_X0         = 10;
  localparam int DEF_SLOT_PITCH = 10;
  localparam int DEF_Y0         = 112;
  localparam int DEF_SQ_SIZE    = 4;

  // Red has priority over yellow; an empty slot is painted black so that
  // notes which moved away are erased.
  function automatic logic [2:0] slot_colour(input logic red_bit, input logic yellow_bit);
    logic [2:0] c;
    if (red_bit) begin
      c = RED;
    end else if (yellow_bit) begin
      c = YELLOW;
    end else begin
      c = BLACK;
    end
    return c;
  endfunction

endpackage

// File: rtl/square_pixel_counter.sv
// square_pixel_counter: walks the SQ_SIZE x SQ_SIZE pixels of one square.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   i_clr    synchronous clear back to pixel 0
//   i_en     advance to the next pixel
//   o_pix    current pixel index {row, column}
//   o_wrap   high when the last pixel is being advanced past
module square_pixel_counter #(
  parameter int SQ_SIZE = 4,
  parameter int PW      = 2 * $clog2(SQ_SIZE)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [PW-1:0] o_pix,
  output logic          o_wrap
);

  logic [PW-1:0] r_pix;

  // Pixel index; SQ_SIZE is a power of two so the index wraps on its own.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pix <= {PW{1'b0}};
    end else if (i_clr) begin
      r_pix <= {PW{1'b0}};
    end else if (i_en) begin
      r_pix <= r_pix + PW'(1);
    end else begin
      r_pix <= r_pix;
    end
  end

  assign o_pix  = r_pix;
  assign o_wrap = i_en & (r_pix == {PW{1'b1}});

endmodule

// File: rtl/note_track_scheduler.sv
// note_track_scheduler: redraws the note track once per frame tick.
// Ports:
//   i_clk              system clock
//   i_resetn           synchronous reset, asserted when 1
//   i_frame_tick       one-cycle redraw request
//   i_red_sequence     red note bits, bit i -> slot i
//   i_yellow_sequence  yellow note bits, bit i -> slot i
//   i_stall            VGA write port not ready
//   o_x, o_y, o_colour pixel coordinate and colour
//   o_plot             pixel write strobe (accepted when i_stall=0)
//   o_busy             frame in progress
//   o_done             one-cycle pulse after the last pixel is accepted
module note_track_scheduler
  import track_pkg::*;
#(
  parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter int X0         = DEF_X0,
  parameter int SLOT_PITCH = DEF_SLOT_PITCH,
  parameter int Y0         = DEF_Y0,
  parameter int SQ_SIZE    = DEF_SQ_SIZE
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic                 i_frame_tick,
  input  logic [NUM_SLOTS-1:0] i_red_sequence,
  input  logic [NUM_SLOTS-1:0] i_yellow_sequence,
  input  logic                 i_stall,
  output logic [7:0]           o_x,
  output logic [6:0]           o_y,
  output logic [2:0]           o_colour,
  output logic                 o_plot,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(SQ_SIZE);
  localparam int PW = 2 * CW;

  state_t               r_state;
  logic                 r_pending;
  logic [SW-1:0]        r_slot;
  logic                 r_issued;
  logic [NUM_SLOTS-1:0] r_red_snap;
  logic [NUM_SLOTS-1:0] r_yel_snap;
  logic [7:0]           r_x;
  logic [6:0]           r_y;
  logic [2:0]           r_colour;
  logic                 r_plot;
  logic                 r_busy;
  logic                 r_done;

  logic [PW-1:0] w_pix;
  logic          w_wrap;
  logic          w_clr;
  logic          w_accept;
  logic          w_load;
  logic          w_last_slot;
  logic [7:0]    w_x;
  logic [6:0]    w_y;
  logic [2:0]    w_colour;

  // The output register always holds the pixel being offered. A new pixel is
  // loaded in LOAD (output empty) and whenever the offered one is accepted,
  // so the counters point at the next pixel still to be offered.
  assign w_clr       = (r_state == IDLE);
  assign w_accept    = (r_state == DRAW) & r_plot & ~i_stall;
  assign w_load      = (r_state == LOAD) | (w_accept & ~r_issued);
  assign w_last_slot = (r_slot == SW'(NUM_SLOTS - 1));

  assign w_x      = 8'(X0) + 8'(SLOT_PITCH) * 8'(r_slot) + 8'(w_pix[CW-1:0]);
  assign w_y      = 7'(Y0) + 7'(w_pix[PW-1:CW]);
  assign w_colour = slot_colour(r_red_snap[r_slot], r_yel_snap[r_slot]);

  square_pixel_counter #(
    .SQ_SIZE (SQ_SIZE),
    .PW      (PW)
  ) u_pix (
    .i_clk   (i_clk),
    .i_reset (i_resetn),
    .i_clr   (w_clr),
    .i_en    (w_load),
    .o_pix   (w_pix),
    .o_wrap  (w_wrap)
  );

  // Frame state machine, slot counter, snapshots and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_resetn) begin
      r_state    <= IDLE;
      r_pending  <= 1'b0;
      r_slot     <= {SW{1'b0}};
      r_issued   <= 1'b0;
      r_red_snap <= {NUM_SLOTS{1'b0}};
      r_yel_snap <= {NUM_SLOTS{1'b0}};
      r_x        <= 8'd0;
      r_y        <= 7'd0;
      r_colour   <= BLACK;
      r_plot     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A tick outside IDLE is remembered once; extra ticks are dropped.
      if (i_frame_tick && (r_state != IDLE)) begin
        r_pending <= 1'b1;
      end else begin
        r_pending <= r_pending;
      end

      case (r_state)
        IDLE: begin
          r_plot <= 1'b0;
          r_busy <= 1'b0;
          if (i_frame_tick || r_pending) begin
            r_state    <= LOAD;
            r_busy     <= 1'b1;
            r_pending  <= 1'b0;
            r_slot     <= {SW{1'b0}};
            r_issued   <= 1'b0;
            r_red_snap <= i_red_sequence;
            r_yel_snap <= i_yellow_sequence;
          end else begin
            r_state <= IDLE;
          end
        end
        LOAD: begin
          r_state <= DRAW;
        end
        DRAW: begin
          if (w_accept && r_issued) begin
            r_state <= FINISH;
            r_plot  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_state <= DRAW;
          end
        end
        FINISH: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      if (w_load) begin
        r_x      <= w_x;
        r_y      <= w_y;
        r_colour <= w_colour;
        r_plot   <= 1'b1;
        if (w_wrap) begin
          r_slot   <= w_last_slot ? {SW{1'b0}} : r_slot + SW'(1);
          r_issued <= w_last_slot;
        end else begin
          r_slot <= r_slot;
        end
      end else begin
        r_x <= r_x;
      end
    end
  end

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_colour = r_colour;
  assign o_plot   = r_plot;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: doc/note_track_scheduler.md
Name: note_track_scheduler

Overview:
- Sequences the per-frame redraw of the note track: 10 note squares, each 4x4 pixels, along the bottom row of the VGA framebuffer.
- On each frame tick it snapshots the red/yellow note shifter windows, walks every slot pixel by pixel and emits one pixel write per accepted cycle to the VGA adapter.
- Sits between the note shifters / frame-rate divider and the vga_adapter write port, and owns all coordinate and colour generation for the track.

Parameters:
- NUM_SLOTS, 10, number of note squares drawn per frame.
- X0, 10, x coordinate of the first slot's left edge.
- SLOT_PITCH, 10, x distance between adjacent slot left edges.
- Y0, 112, y coordinate of the top edge of every square.
- SQ_SIZE, 4, square edge length in pixels (power of two).

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-high reset. The codebase port name is kept; the reset is asserted when the signal is 1.
- frame_tick  in  1  one-cycle pulse requesting a redraw.
- red_sequence  in  NUM_SLOTS  red note bits; bit i maps to slot i.
- yellow_sequence  in  NUM_SLOTS  yellow note bits; bit i maps to slot i.
- stall  in  1  VGA write port not ready; holds the current pixel.
- x  out  8  pixel x coordinate.
- y  out  7  pixel y coordinate.
- colour  out  3  pixel colour, 3-bit RGB.
- plot  out  1  pixel write strobe; the pixel is accepted when plot=1 and stall=0.
- busy  out  1  high from the LOAD state through the last pixel.
- done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset values (on clk edge with resetn=1): state=IDLE, x=0, y=0, colour=BLACK (000), plot=0, busy=0, done=0, pending=0, slot=0, pix=0. Reset overrides everything, including mid-frame and a simultaneous frame_tick.
- Colour encoding: BLACK=000, RED=100, YELLOW=110.
- Slot colour rule, from the latched snapshot:
  - red bit set -> RED (red wins when both bits are set);
  - else yellow bit set -> YELLOW;
  - else BLACK, so empty slots are erased each frame.
- IDLE:
  - plot=0, busy=0;
  - frame_tick or pending -> LOAD.
- LOAD (1 cycle):
  - latch red_sequence and yellow_sequence into snapshot registers;
  - clear pending; set slot=0, pix=0; busy=1.
  - Next state: DRAW.
- DRAW:
  - plot=1;
  - x = X0 + slot*SLOT_PITCH + pix[1:0];
  - y = Y0 + pix[3:2];
  - colour from the slot rule.
  - Outputs are registered and update on the cycle after the counters change.
  - When a pixel is accepted (stall=0), pix increments. When pix wraps from SQ_SIZE*SQ_SIZE-1 to 0, slot increments.
  - Accepting pixel 15 of slot NUM_SLOTS-1 -> FINISH.
  - While stall=1, x, y, colour and plot=1 hold and the counters freeze.
- FINISH (1 cycle):
  - plot=0, done=1, busy=0.
  - Next state: IDLE; pending, if set, restarts the sequence on the following cycle.
- Latency:
  - frame_tick in IDLE -> LOAD next cycle -> first plot the cycle after LOAD;
  - with no stalls, 160 plot cycles follow, then done;
  - done is high exactly 163 cycles after the tick cycle.
- frame_tick while busy sets pending (one deep); further ticks are dropped. Inputs changing mid-frame do not affect the current frame.
- Width rules:
  - x is computed in 8 bits; the last slot's right edge is 10+9*10+3=103, so no overflow occurs with the defaults;
  - y max = 115;
  - slot counter is clog2(NUM_SLOTS) bits; pix counter is 2*clog2(SQ_SIZE) bits.

Decomposition:
- Shared package track_pkg:
  - colour localparams BLACK, RED, YELLOW, GREEN=010, BLUE=001;
  - state encoding IDLE, LOAD, DRAW, FINISH;
  - default geometry constants (X0, Y0, SLOT_PITCH, SQ_SIZE).
- One sub-module, square_pixel_counter: the SQ_SIZE x SQ_SIZE pixel walker with enable (accept) input, pix outputs and a wrap pulse.
- Top-level scheduler holds the state machine, slot counter, snapshot registers and output registers.

Test Plan:
- Reset with red=10'h3FF, then frame_tick, no stall -> first pixel (x=10, y=112, colour=100); last pixel (x=103, y=115, colour=100); 160 plots; done at tick+163.
- red=10'b0000000001, yellow=10'b1000000010 -> slot0 RED, slot1 YELLOW, slot9 YELLOW, slots 2-8 BLACK.
- red=yellow=10'b1 -> slot0 drawn RED (red priority).
- stall held high for 5 cycles on pixel (x=31, y=113) -> pixel held, still 160 accepted plots, done delayed by 5 cycles.
- Two frame_ticks during a frame -> exactly one extra frame runs, starting the cycle after done; the second tick is dropped.
- resetn=1 at plot #50 -> next cycle plot=0, busy=0, state IDLE; a new tick restarts at x=10, y=112.
